// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches; trains the predictor on resolve and squashes wrong-path entries on mispredict.
// Optional macro BRQ_STATS_EN adds branch/mispredict statistics counters.
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    input  logic [31:0]      enq_pc,
    input  logic             enq_pred,
    output logic             enq_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic             flush,
    output logic             is_branch,
    output logic [31:0]      pc_to_update,
    output logic             branch_taken,
    output logic             mispredict,
`ifdef BRQ_STATS_EN
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts,
`endif
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      pc_mem   [DEPTH];
    logic             pred_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_enq;
    logic             do_res;
    logic             miss;
    logic [31:0]      head_pc;
    logic             head_pred;

    assign enq_ready = (count != FULL_CNT);

    always_comb begin
        do_enq    = enq_valid && enq_ready;
        do_res    = res_valid && (count != '0);
        head_pc   = pc_mem[head];
        head_pred = pred_mem[head];
        miss      = do_res && (res_taken != head_pred);
    end

    // Storage writes are unconditional on accept; a flush or squash just moves tail back over them.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_mem[tail]   <= enq_pc;
            pred_mem[tail] <= enq_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            is_branch    <= 1'b0;
            pc_to_update <= '0;
            branch_taken <= 1'b0;
            mispredict   <= 1'b0;
        end else begin
            is_branch  <= 1'b0;
            mispredict <= 1'b0;
            if (flush) begin
                tail  <= head;
                count <= '0;
            end else begin
                if (do_res) begin
                    head         <= head + PTR_W'(1);
                    is_branch    <= 1'b1;
                    pc_to_update <= head_pc;
                    branch_taken <= res_taken;
                    mispredict   <= miss;
                end
                // Squash is applied at the resolve edge so the queue reads empty alongside the mispredict pulse.
                if (miss) begin
                    tail  <= head + PTR_W'(1);
                    count <= '0;
                end else begin
                    if (do_enq)
                        tail <= tail + PTR_W'(1);
                    if (do_enq && !do_res)
                        count <= count + (PTR_W+1)'(1);
                    else if (do_res && !do_enq)
                        count <= count - (PTR_W+1)'(1);
                end
            end
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (is_branch)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
